seq_shift_add_mult_ctrl: RTL and testbench



---
 rtl/seq_shift_add_mult_ctrl_pkg.sv | 12 +
 rtl/seq_shift_add_mult_ctrl_adder.sv | 28 ++
 rtl/seq_shift_add_mult_ctrl.sv | 81 ++++++++
 tb/tb_seq_shift_add_mult_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/seq_shift_add_mult_ctrl_pkg.sv
// seq_shift_add_mult_ctrl_pkg: shared state encoding and sizing helpers for the shift-add multiplier
package mult_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W = $clog2(DEF_WIDTH + 1);
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_shift_add_mult_ctrl_adder.sv
// seq_shift_add_mult_ctrl_adder: WIDTH-bit ripple adder built from chained full_adder cells
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder_w #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  assign cout = c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
endmodule

// File: rtl/seq_shift_add_mult_ctrl.sv
// seq_shift_add_mult_ctrl: sequential shift-add multiplier sharing one ripple adder; SHIFT_ADD_EARLY_TERM_EN enables early termination
module seq_shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_n;
  logic [WIDTH-1:0] mcand, acc, q, addend, s, acc_n, q_n;
  logic carry, c, finish;
  logic [CW-1:0] count;
  logic [2*WIDTH-1:0] p_n;
  assign addend = q[0] ? mcand : '0;
  // carry is the bit shifted out above acc; it is always zero after the shift, so as carry-in it adds nothing
  ripple_adder_w #(.WIDTH(WIDTH)) u_add (.a(acc), .b(addend), .cin(carry), .sum(s), .cout(c));
  assign acc_n = {c, s[WIDTH-1:1]};
  assign q_n = {s[0], q[WIDTH-1:1]};
`ifdef SHIFT_ADD_EARLY_TERM_EN
  logic [CW-1:0] shamt;
  logic [WIDTH-1:0] rem_mask;
  // after this step the low shamt bits of q_n are still-unconsumed multiplier bits
  assign shamt = LAST - count;
  assign rem_mask = (WIDTH'(1) << shamt) - WIDTH'(1);
  assign finish = (q_n & rem_mask) == '0;
  assign p_n = {acc_n, q_n} >> shamt;
`else
  assign finish = count == LAST;
  assign p_n = {acc_n, q_n};
`endif
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  // next-state logic
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (finish ? DONE : RUN) :
              state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // handshake and status outputs decoded from state
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state == RUN;
  end
  // datapath: load on accept, shift-add while running, capture product on the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc <= '0;
      q <= '0;
      carry <= 1'b0;
      count <= '0;
      p <= '0;
    end else if (in_ready && in_valid) begin
      mcand <= a;
      q <= b;
      acc <= '0;
      carry <= 1'b0;
      count <= '0;
    end else if (busy) begin
      acc <= acc_n;
      q <= q_n;
      carry <= 1'b0;
      count <= count + 1'b1;
      if (finish) p <= p_n;
    end
  end
endmodule

// File: tb/tb_seq_shift_add_mult_ctrl.sv
// tb_seq_shift_add_mult_ctrl: table vectors, corner sequences and randomized regression against a*b
module tb_seq_shift_add_mult_ctrl;
  localparam int W = 4;
`ifdef SHIFT_ADD_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic in_ready, out_valid, busy;
  logic [2*W-1:0] p;
  int n_run = 0;
  int n_fail = 0;
  int hs_seen = 0;
  int hs_exp = 0;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] p;
    int stall;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  seq_shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );
  always @(posedge clk) if (!rst && out_valid && out_ready) hs_seen++;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  // latency = cycles until the highest set multiplier bit has been consumed (early) or always W
  function automatic int ref_lat(input logic [W-1:0] bv);
    int h = 0;
    for (int i = 0; i < W; i++) if (bv[i]) h = i + 1;
    return EARLY ? (h == 0 ? 1 : h) : W;
  endfunction
  task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2*W-1:0] exp_p,
                     input int stall, input string nm);
    int lat = 0;
    int guard = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, " in_ready"}, 32'(in_ready), 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    while (!out_valid && lat < 2 * W + 4) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " out_valid"}, 32'(out_valid), 1);
    if (!out_valid) return;
    chk({nm, " latency"}, lat, ref_lat(bv));
    chk({nm, " p"}, 32'(p), 32'(exp_p));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      chk({nm, " stall out_valid"}, 32'(out_valid), 1);
      chk({nm, " stall in_ready"}, 32'(in_ready), 0);
      chk({nm, " stall p"}, 32'(p), 32'(exp_p));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    hs_exp++;
    chk({nm, " post out_valid"}, 32'(out_valid), 0);
    chk({nm, " post in_ready"}, 32'(in_ready), 1);
    chk({nm, " post p kept"}, 32'(p), 32'(exp_p));
  endtask
  initial begin
    tbl[0] = '{a: 4'd13, b: 4'd11, p: 8'h8F, stall: 0};
    tbl[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1, stall: 2};
    tbl[2] = '{a: 4'd0,  b: 4'd9,  p: 8'h00, stall: 0};
    tbl[3] = '{a: 4'd7,  b: 4'd0,  p: 8'h00, stall: 5};
    tbl[4] = '{a: 4'd12, b: 4'd1,  p: 8'd12, stall: 0};
    tbl[5] = '{a: 4'd9,  b: 4'd2,  p: 8'd18, stall: 1};
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset p", 32'(p), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].stall, $sformatf("vec%0d", i));
    a = 4'd6;
    b = 4'd5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst in_ready", 32'(in_ready), 1);
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst busy idle", 32'(busy), 0);
    chk("midrst p", 32'(p), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst no out_valid", 32'(out_valid), 0);
    end
    run(4'd6, 4'd5, 8'd30, 0, "after_rst");
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      run(ra, rb, (2*W)'(ra) * (2*W)'(rb), int'($urandom_range(0, 3)), "rand");
    end
    chk("handshake count", hs_seen, hs_exp);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
